// File: rtl/svn_seg_rx.sv
// -----------------------------------------------------------------------------
// svn_seg_rx -- seven-segment receive decoder.
//
// Samples a multiplexed common-cathode display bus coming in from an external
// display driver, waits for each digit strobe to settle, decodes the segment
// pattern back to a 4-bit code and assembles a full frame. Once every digit
// position has been captured the frame is published with a one-cycle VALID.
//
// Optional feature: define SVN_SEG_RX_ERR_EN to enable the invalid-pattern
// flag on ERR. Without it ERR is tied low (0xE codes still reach DIGITS).
//
// Parameters:
//   NDIG        number of multiplexed digit positions (1..8)
//   STABLE_CNT  identical synchronized samples needed before a capture (2..255)
//
// Ports:
//   CLK     in   system clock, all state on posedge
//   RST     in   asynchronous active-high reset
//   SEG     in   [7:0] segment lines (bit7 = DP, bits6:0 = g..a), async to CLK
//   COM     in   [NDIG-1:0] one-hot digit strobes, async to CLK
//   DIGITS  out  [4*NDIG-1:0] published frame, nibble i = position i
//   DP      out  [NDIG-1:0] published decimal points
//   VALID   out  one-cycle pulse when DIGITS/DP update
//   ERR     out  published frame contains an invalid (0xE) pattern
// -----------------------------------------------------------------------------
module svn_seg_rx #(
    parameter int NDIG       = 4,
    parameter int STABLE_CNT = 3
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [7:0]          SEG,
    input  logic [NDIG-1:0]     COM,
    output logic [4*NDIG-1:0]   DIGITS,
    output logic [NDIG-1:0]     DP,
    output logic                VALID,
    output logic                ERR
);

    localparam logic [7:0] STABLE_Q = 8'(STABLE_CNT);

    typedef enum logic {
        SETTLE = 1'b0,
        HELD   = 1'b1
    } state_t;

    function automatic logic [3:0] seg_decode(input logic [6:0] pat);
        logic [3:0] code;
        case (pat)
            7'h3F:   code = 4'h0;
            7'h06:   code = 4'h1;
            7'h5B:   code = 4'h2;
            7'h4F:   code = 4'h3;
            7'h66:   code = 4'h4;
            7'h6D:   code = 4'h5;
            7'h7D:   code = 4'h6;
            7'h07:   code = 4'h7;
            7'h7F:   code = 4'h8;
            7'h6F:   code = 4'h9;
            7'h7B:   code = 4'h9;
            7'h00:   code = 4'hF;
            default: code = 4'hE;
        endcase
        return code;
    endfunction

    function automatic logic is_onehot(input logic [NDIG-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

    // synchronizer stage 1, stage 2 (sample S) and previous sample P
    logic [7:0]        seg_s1_q, seg_s1_d, seg_s2_q, seg_s2_d, seg_p_q, seg_p_d;
    logic [NDIG-1:0]   com_s1_q, com_s1_d, com_s2_q, com_s2_d, com_p_q, com_p_d;

    logic [7:0]        cnt_q, cnt_d;
    state_t            state_q, state_d;
    logic [NDIG-1:0]   mask_q, mask_d;
    logic [4*NDIG-1:0] slot_code_q, slot_code_d;
    logic [NDIG-1:0]   slot_dp_q, slot_dp_d;
    logic [4*NDIG-1:0] digits_q, digits_d;
    logic [NDIG-1:0]   dp_q, dp_d;
    logic              valid_q, valid_d;

    logic              s_ne_p;
    logic              front_ok;
    logic              capture;
    logic              publish;
    logic [3:0]        code;

    always_comb begin
        seg_s1_d = SEG;
        com_s1_d = COM;
        seg_s2_d = seg_s1_q;
        com_s2_d = com_s1_q;
        seg_p_d  = seg_s2_q;
        com_p_d  = com_s2_q;

        code     = seg_decode(seg_s2_q[6:0]);
        s_ne_p   = (seg_s2_q != seg_p_q) || (com_s2_q != com_p_q);

        // settle counter saturates at STABLE_CNT
        if (s_ne_p || !is_onehot(com_s2_q)) begin
            cnt_d = 8'd0;
        end else if (cnt_q >= STABLE_Q) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end

        // The front synchronizer stage must still agree with S on the capture
        // edge; this is what makes the minimum strobe dwell STABLE_CNT+2
        // cycles rather than STABLE_CNT+1.
        front_ok = (seg_s1_q == seg_s2_q) && (com_s1_q == com_s2_q);
        capture  = (state_q == SETTLE) && (cnt_d == STABLE_Q) && front_ok;

        state_d = state_q;
        case (state_q)
            SETTLE:  if (capture) state_d = HELD;
            HELD:    if (s_ne_p)  state_d = SETTLE;
            default: state_d = SETTLE;
        endcase

        // Publish on the cycle after the mask fills; a capture on that same
        // edge is the first slot of the next frame.
        publish     = &mask_q;
        mask_d      = publish ? '0 : mask_q;
        slot_code_d = slot_code_q;
        slot_dp_d   = slot_dp_q;
        for (int i = 0; i < NDIG; i++) begin
            if (capture && com_s2_q[i]) begin
                slot_code_d[4*i +: 4] = code;
                slot_dp_d[i]          = seg_s2_q[7];
                mask_d[i]             = 1'b1;
            end
        end

        digits_d = publish ? slot_code_q : digits_q;
        dp_d     = publish ? slot_dp_q   : dp_q;
        valid_d  = publish;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            seg_s1_q    <= '0;
            com_s1_q    <= '0;
            seg_s2_q    <= '0;
            com_s2_q    <= '0;
            seg_p_q     <= '0;
            com_p_q     <= '0;
            cnt_q       <= 8'd0;
            state_q     <= SETTLE;
            mask_q      <= '0;
            slot_code_q <= '1;
            slot_dp_q   <= '0;
            digits_q    <= '1;
            dp_q        <= '0;
            valid_q     <= 1'b0;
        end else begin
            seg_s1_q    <= seg_s1_d;
            com_s1_q    <= com_s1_d;
            seg_s2_q    <= seg_s2_d;
            com_s2_q    <= com_s2_d;
            seg_p_q     <= seg_p_d;
            com_p_q     <= com_p_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            mask_q      <= mask_d;
            slot_code_q <= slot_code_d;
            slot_dp_q   <= slot_dp_d;
            digits_q    <= digits_d;
            dp_q        <= dp_d;
            valid_q     <= valid_d;
        end
    end

    assign DIGITS = digits_q;
    assign DP     = dp_q;
    assign VALID  = valid_q;

`ifdef SVN_SEG_RX_ERR_EN
    // One invalid bit per slot, rewritten by every capture so that an
    // overwritten bad slot does not taint the frame.
    logic [NDIG-1:0] bad_q, bad_d;
    logic            err_q, err_d;

    always_comb begin
        bad_d = publish ? '0 : bad_q;
        for (int i = 0; i < NDIG; i++) begin
            if (capture && com_s2_q[i]) begin
                bad_d[i] = (code == 4'hE);
            end
        end
        err_d = publish && (|bad_q);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bad_q <= '0;
            err_q <= 1'b0;
        end else begin
            bad_q <= bad_d;
            err_q <= err_d;
        end
    end

    assign ERR = err_q;
`else
    assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_svn_seg_rx.sv
// -----------------------------------------------------------------------------
// tb_svn_seg_rx -- scoreboard bench for svn_seg_rx (NDIG=4, STABLE_CNT=3).
// Stimulus pushes the hand-computed expected frame into a queue; a monitor
// pops and compares each time VALID is seen.
// -----------------------------------------------------------------------------
module tb_svn_seg_rx;

    localparam int NDIG       = 4;
    localparam int STABLE_CNT = 3;
`ifdef SVN_SEG_RX_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] digits;
        logic [3:0]  dp;
        logic        err;
    } exp_t;

    logic            CLK = 1'b0;
    logic            RST;
    logic [7:0]      SEG;
    logic [NDIG-1:0] COM;
    logic [15:0]     DIGITS;
    logic [3:0]      DP;
    logic            VALID;
    logic            ERR;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   valid_seen = 0;
    int   pushed     = 0;
    int   last_valid_cyc = -1;
    bit   done = 1'b0;
    exp_t exp_q[$];

    svn_seg_rx #(.NDIG(NDIG), .STABLE_CNT(STABLE_CNT)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .SEG    (SEG),
        .COM    (COM),
        .DIGITS (DIGITS),
        .DP     (DP),
        .VALID  (VALID),
        .ERR    (ERR)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // monitor: compare every published frame against the scoreboard
    always @(negedge CLK) begin
        if (!RST && VALID) begin
            valid_seen++;
            last_valid_cyc = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid: got DIGITS=0x%0h at cycle %0d, expected no VALID", DIGITS, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("frame_digits", 32'(DIGITS), 32'(e.digits));
                chk("frame_dp",     32'(DP),     32'(e.dp));
                chk("frame_err",    32'(ERR),    32'(e.err));
            end
        end
    end

    task automatic push(input logic [15:0] d, input logic [3:0] dp, input logic err);
        exp_t e;
        e.digits = d;
        e.dp     = dp;
        e.err    = err;
        exp_q.push_back(e);
        pushed++;
    endtask

    // drive one strobe position for n cycles (called at a negedge)
    task automatic show(input int pos, input logic [7:0] seg, input int n);
        COM = 4'(1 << pos);
        SEG = seg;
        repeat (n) @(negedge CLK);
    endtask

    task automatic gap(input int n);
        COM = '0;
        SEG = 8'h00;
        repeat (n) @(negedge CLK);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_digits"}, 32'(DIGITS), 32'hFFFF);
        chk({tag, "_dp"},     32'(DP),     32'h0);
        chk({tag, "_valid"},  32'(VALID),  32'h0);
        chk({tag, "_err"},    32'(ERR),    32'h0);
    endtask

    initial begin
        #200000;
        if (!done) begin
            $display("FAIL watchdog: got timeout, expected bench completion");
            $fatal(1, "watchdog expired");
        end
    end

    initial begin
        int t0;
        RST = 1'b1;
        COM = '0;
        SEG = 8'h00;
        repeat (2) @(negedge CLK);
        chk_reset_outputs("por");
        RST = 1'b0;
        gap(4);

        // basic scan 1,2,3,4
        show(0, 8'h06, 10); show(1, 8'h5B, 10); show(2, 8'h4F, 10);
        push(16'h4321, 4'b0000, 1'b0);
        show(3, 8'h66, 10); gap(8);

        // 8, blank, alternate 9, 0 with DP
        show(0, 8'h7F, 10); show(1, 8'h00, 10); show(2, 8'h7B, 10);
        push(16'h09F8, 4'b1000, 1'b0);
        show(3, 8'hBF, 10); gap(8);

        // minimum dwell (STABLE_CNT+2 = 5) still captures; standard 9 on pos 2
        show(0, 8'h3F, 5); show(1, 8'h7D, 5); show(2, 8'h6F, 5);
        push(16'h7960, 4'b0000, 1'b0);
        show(3, 8'h07, 5); gap(8);

        // 4-cycle strobe on pos 1 is ignored; frame completes only later
        show(0, 8'h06, 10); show(1, 8'h7F, 4); show(2, 8'h4F, 10); show(3, 8'h66, 10);
        gap(6);
        push(16'h4321, 4'b0000, 1'b0);
        show(1, 8'h5B, 10); gap(8);

        // two strobes at once for 20 cycles: no capture
        show(0, 8'h6D, 10);
        COM = 4'b0011; SEG = 8'h7F; repeat (20) @(negedge CLK);
        show(2, 8'h66, 10); show(3, 8'h07, 10); gap(6);
        push(16'h7465, 4'b0000, 1'b0);
        show(1, 8'h7D, 10); gap(8);

        // 1-cycle SEG flip mid-dwell restarts the count
        show(0, 8'h06, 10); show(2, 8'h5B, 10); show(3, 8'h4F, 10); gap(4);
        push(16'h3221, 4'b0000, 1'b0);
        t0 = cyc;
        show(1, 8'h5B, 3); show(1, 8'h4F, 1); show(1, 8'h5B, 8); gap(8);
        // capture 9 edges after first sample, VALID one edge later
        chk("flip_valid_cycle", 32'(last_valid_cyc), 32'(t0 + 11));

        // invalid pattern on pos 1
        show(0, 8'h3F, 10); show(1, 8'h49, 10); show(2, 8'h3F, 10);
        push(16'h00E0, 4'b0000, ERR_EN);
        show(3, 8'h3F, 10); gap(8);

        // clean frame afterwards drops ERR
        show(0, 8'h66, 10); show(1, 8'h4F, 10); show(2, 8'h5B, 10);
        push(16'h1234, 4'b0000, 1'b0);
        show(3, 8'h06, 10); gap(8);

        // repeat capture of pos 1: latest wins, one VALID
        show(0, 8'h3F, 10); show(1, 8'h06, 10); show(2, 8'h5B, 10); show(1, 8'h7D, 10);
        push(16'h3260, 4'b0000, 1'b0);
        show(3, 8'h4F, 10); gap(8);

        // async reset mid-frame discards partial frame
        show(0, 8'h06, 10); show(1, 8'h5B, 10); gap(1);
        #2 RST = 1'b1;
        #1 chk_reset_outputs("midrst");
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        gap(2);
        show(2, 8'h4F, 10); show(3, 8'h66, 10); gap(6);
        show(0, 8'h7F, 10);
        push(16'h4398, 4'b0000, 1'b0);
        show(1, 8'h6F, 10); gap(20);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        chk("valid_count", 32'(valid_seen), 32'(pushed));

        done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
